// File: rtl/motoro3_hall_decoder.sv
// Hall sensor sync/debounce/sector decoder reporting direction, edge period, stall and sequence errors.
// Latency: DEBOUNCE_CYC+3 cycles from a stable raw input change to outputs; no backpressure (free-running sensor input).
module motoro3_hall_decoder #(
    parameter int DEBOUNCE_CYC = 16,
    parameter int PERIOD_W     = 25,
    parameter int TIMEOUT      = 10_000_000
) (
    input  logic                clk,
    input  logic                nRst,
    input  logic                hallA,
    input  logic                hallB,
    input  logic                hallC,
    input  logic                clrErr,
    output logic [2:0]          hStep,
    output logic                hValid,
    output logic                hDir,
    output logic                hEdge,
    output logic [PERIOD_W-1:0] hPeriod,
    output logic                hPeriodValid,
    output logic                hStall,
    output logic                hErr,
    output logic [7:0]          hErrCnt
);

    localparam int                  DEB_W   = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [DEB_W-1:0]    DEB_MAX = DEB_W'(DEBOUNCE_CYC);
    localparam logic [PERIOD_W-1:0] TMO     = PERIOD_W'(TIMEOUT);

    typedef enum logic [1:0] {NOREF, ONE, RUN} state_t;

    logic [2:0]          sync1_q, sync1_d, sync2_q, sync2_d;
    logic [2:0]          cand_q, cand_d, acc_q, acc_d;
    logic [DEB_W-1:0]    deb_cnt_q, deb_cnt_d;
    state_t              state_q, state_d;
    logic [2:0]          step_q, step_d;
    logic                valid_q, valid_d, dir_q, dir_d, edge_q, edge_d;
    logic                pv_q, pv_d, stall_q, stall_d, err_q, err_d;
    logic                dir_known_q, dir_known_d;
    logic [PERIOD_W-1:0] period_q, period_d, cnt_q, cnt_d;
    logic [7:0]          err_cnt_q, err_cnt_d;

    logic                accept, new_ok, err_evt;
    logic [2:0]          new_step;
    logic [3:0]          delta;
    logic [PERIOD_W-1:0] cnt_inc;

    function automatic logic [2:0] sector(input logic [2:0] code);
        case (code)
            3'b100:  return 3'd0;
            3'b110:  return 3'd1;
            3'b010:  return 3'd2;
            3'b011:  return 3'd3;
            3'b001:  return 3'd4;
            3'b101:  return 3'd5;
            default: return 3'd7;
        endcase
    endfunction

    // Debounce: the counter measures how long the synchronised code has matched the candidate.
    always_comb begin
        sync1_d   = {hallA, hallB, hallC};
        sync2_d   = sync1_q;
        cand_d    = sync2_q;
        deb_cnt_d = deb_cnt_q;
        if (sync2_q != cand_q) begin
            deb_cnt_d = DEB_W'(1);
        end else if (deb_cnt_q != DEB_MAX) begin
            deb_cnt_d = deb_cnt_q + 1'b1;
        end
    end

    always_comb begin
        accept   = (deb_cnt_q == DEB_MAX) && (cand_q != acc_q);
        new_step = sector(cand_q);
        new_ok   = (new_step != 3'd7);
        delta    = {1'b0, new_step} + 4'd6 - {1'b0, step_q};
        if (delta >= 4'd6) begin
            delta = delta - 4'd6;
        end
        cnt_inc  = (cnt_q >= TMO) ? TMO : cnt_q + 1'b1;
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        step_d      = step_q;
        valid_d     = valid_q;
        dir_d       = dir_q;
        dir_known_d = dir_known_q;
        edge_d      = 1'b0;
        err_evt     = 1'b0;
        period_d    = period_q;
        pv_d        = pv_q;
        stall_d     = stall_q;
        cnt_d       = cnt_q;

        if (state_q != NOREF) begin
            cnt_d = cnt_inc;
            if (cnt_inc == TMO) begin
                stall_d = 1'b1;
                pv_d    = 1'b0;
                state_d = ONE;
            end
        end

        // Anything accepted this cycle overrides the timeout path, so an edge beats a stall.
        if (accept) begin
            acc_d = cand_q;
            if (!new_ok) begin
                err_evt     = 1'b1;
                step_d      = 3'd7;
                valid_d     = 1'b0;
                pv_d        = 1'b0;
                cnt_d       = '0;
                dir_known_d = 1'b0;
                state_d     = NOREF;
            end else if (state_q == NOREF) begin
                step_d      = new_step;
                valid_d     = 1'b1;
                cnt_d       = '0;
                dir_known_d = 1'b0;
                state_d     = ONE;
            end else if (delta == 4'd1 || delta == 4'd5) begin
                edge_d      = 1'b1;
                step_d      = new_step;
                stall_d     = 1'b0;
                cnt_d       = '0;
                dir_known_d = 1'b1;
                if (((delta == 4'd1) == dir_q) && !stall_q && dir_known_q) begin
                    period_d = cnt_inc;
                    pv_d     = 1'b1;
                    state_d  = RUN;
                end else begin
                    dir_d    = (delta == 4'd1);
                    pv_d     = 1'b0;
                    state_d  = ONE;
                end
            end else begin
                err_evt = 1'b1;
                step_d  = new_step;
                pv_d    = 1'b0;
                cnt_d   = '0;
                state_d = ONE;
            end
        end

        err_d     = err_evt;
        err_cnt_d = err_cnt_q;
        if (clrErr) begin
            err_cnt_d = '0;
        end else if (err_evt && err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!nRst) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            cand_q      <= '0;
            acc_q       <= '0;
            deb_cnt_q   <= '0;
            state_q     <= NOREF;
            step_q      <= 3'd7;
            valid_q     <= 1'b0;
            dir_q       <= 1'b0;
            dir_known_q <= 1'b0;
            edge_q      <= 1'b0;
            period_q    <= '0;
            pv_q        <= 1'b0;
            stall_q     <= 1'b0;
            err_q       <= 1'b0;
            err_cnt_q   <= '0;
            cnt_q       <= '0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            cand_q      <= cand_d;
            acc_q       <= acc_d;
            deb_cnt_q   <= deb_cnt_d;
            state_q     <= state_d;
            step_q      <= step_d;
            valid_q     <= valid_d;
            dir_q       <= dir_d;
            dir_known_q <= dir_known_d;
            edge_q      <= edge_d;
            period_q    <= period_d;
            pv_q        <= pv_d;
            stall_q     <= stall_d;
            err_q       <= err_d;
            err_cnt_q   <= err_cnt_d;
            cnt_q       <= cnt_d;
        end
    end

    assign hStep        = step_q;
    assign hValid       = valid_q;
    assign hDir         = dir_q;
    assign hEdge        = edge_q;
    assign hPeriod      = period_q;
    assign hPeriodValid = pv_q;
    assign hStall       = stall_q;
    assign hErr         = err_q;
    assign hErrCnt      = err_cnt_q;

endmodule

// File: tb/tb_motoro3_hall_decoder.sv
// Bench for motoro3_hall_decoder: vector table driven into a latency-checked scoreboard plus hand-written corner sequences.
module tb_motoro3_hall_decoder;

    localparam int DEB = 16;
    localparam int TMO = 2000;
    localparam int PW  = 25;
    localparam int LAT = DEB + 3;

    logic          clk = 1'b0;
    logic          nRst = 1'b0;
    logic          hallA = 1'b0, hallB = 1'b0, hallC = 1'b0;
    logic          clrErr = 1'b0;
    logic [2:0]    hStep;
    logic          hValid, hDir, hEdge, hPeriodValid, hStall, hErr;
    logic [PW-1:0] hPeriod;
    logic [7:0]    hErrCnt;

    motoro3_hall_decoder #(.DEBOUNCE_CYC(DEB), .PERIOD_W(PW), .TIMEOUT(TMO)) dut (
        .clk(clk), .nRst(nRst), .hallA(hallA), .hallB(hallB), .hallC(hallC), .clrErr(clrErr),
        .hStep(hStep), .hValid(hValid), .hDir(hDir), .hEdge(hEdge), .hPeriod(hPeriod),
        .hPeriodValid(hPeriodValid), .hStall(hStall), .hErr(hErr), .hErrCnt(hErrCnt)
    );

    always #50 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            cyc;
        logic [2:0]    step;
        logic          valid, dir, edg, err, pv, stall;
        logic [PW-1:0] period;
        logic [7:0]    ecnt;
    } exp_t;

    typedef struct {
        logic [2:0] hall;
        int         dwell;
        bit         evt;
        exp_t       e;
    } vec_t;

    exp_t       sb[$];
    exp_t       mon_e;
    int         n_chk = 0;
    int         n_bad = 0;
    bit         mon_en = 1'b0;
    logic [2:0] prev_step = 3'd7;
    vec_t       tbl[19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t mk(input logic [2:0] step, input logic valid, input logic dir,
                                input logic edg, input logic err, input logic pv,
                                input int period, input int ecnt, input logic stall);
        exp_t e;
        e.cyc = 0; e.step = step; e.valid = valid; e.dir = dir; e.edg = edg; e.err = err;
        e.pv = pv; e.period = PW'(period); e.ecnt = 8'(ecnt); e.stall = stall;
        return e;
    endfunction

    function automatic vec_t vv(input logic [2:0] hall, input int dwell, input bit evt,
                                input logic [2:0] step, input logic valid, input logic dir,
                                input logic edg, input logic err, input logic pv,
                                input int period, input int ecnt);
        vec_t v;
        v.hall = hall; v.dwell = dwell; v.evt = evt;
        v.e = mk(step, valid, dir, edg, err, pv, period, ecnt, 1'b0);
        return v;
    endfunction

    // Called just after a clock edge: the new code is first captured on the next edge.
    task automatic drive(input logic [2:0] h, input bit evt, input exp_t e);
        {hallA, hallB, hallC} = h;
        if (evt) begin
            e.cyc = cyc + LAT;
            sb.push_back(e);
        end
    endtask

    task automatic apply(input vec_t v);
        @(posedge clk); #1;
        drive(v.hall, v.evt, v.e);
        repeat (v.dwell - 1) @(posedge clk);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_step"},   32'(hStep), 7);
        chk({tag, "_valid"},  32'(hValid), 0);
        chk({tag, "_dir"},    32'(hDir), 0);
        chk({tag, "_edge"},   32'(hEdge), 0);
        chk({tag, "_period"}, 32'(hPeriod), 0);
        chk({tag, "_pv"},     32'(hPeriodValid), 0);
        chk({tag, "_stall"},  32'(hStall), 0);
        chk({tag, "_err"},    32'(hErr), 0);
        chk({tag, "_errcnt"}, 32'(hErrCnt), 0);
    endtask

    // Every accepted change shows up as exactly one cycle with hEdge, hErr or a new hStep.
    always @(negedge clk) begin
        if (mon_en && (hEdge || hErr || hStep != prev_step)) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_bad++;
                $display("FAIL unexpected_event: step=%0d edge=%0d err=%0d at cycle %0d, expected no event",
                         hStep, hEdge, hErr, cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("evt_cycle",  32'(cyc), 32'(mon_e.cyc));
                chk("evt_step",   32'(hStep), 32'(mon_e.step));
                chk("evt_valid",  32'(hValid), 32'(mon_e.valid));
                chk("evt_dir",    32'(hDir), 32'(mon_e.dir));
                chk("evt_edge",   32'(hEdge), 32'(mon_e.edg));
                chk("evt_err",    32'(hErr), 32'(mon_e.err));
                chk("evt_pv",     32'(hPeriodValid), 32'(mon_e.pv));
                chk("evt_period", 32'(hPeriod), 32'(mon_e.period));
                chk("evt_errcnt", 32'(hErrCnt), 32'(mon_e.ecnt));
                chk("evt_stall",  32'(hStall), 32'(mon_e.stall));
            end
        end
        prev_step = hStep;
    end

    initial begin
        exp_t e;
        //              hall    dwell evt step val dir edg err pv  period ecnt
        tbl[0]  = vv(3'b110, 500, 1, 3'd1, 1, 1, 1, 0, 0,   0, 0);
        tbl[1]  = vv(3'b010, 500, 1, 3'd2, 1, 1, 1, 0, 1, 500, 0);
        tbl[2]  = vv(3'b011, 500, 1, 3'd3, 1, 1, 1, 0, 1, 500, 0);
        tbl[3]  = vv(3'b001, 500, 1, 3'd4, 1, 1, 1, 0, 1, 500, 0);
        tbl[4]  = vv(3'b101, 500, 1, 3'd5, 1, 1, 1, 0, 1, 500, 0);
        tbl[5]  = vv(3'b100, 500, 1, 3'd0, 1, 1, 1, 0, 1, 500, 0);
        tbl[6]  = vv(3'b110, 500, 1, 3'd1, 1, 1, 1, 0, 1, 500, 0);
        tbl[7]  = vv(3'b010, 500, 1, 3'd2, 1, 1, 1, 0, 1, 500, 0);
        tbl[8]  = vv(3'b011, 500, 1, 3'd3, 1, 1, 1, 0, 1, 500, 0);
        tbl[9]  = vv(3'b010, 500, 1, 3'd2, 1, 0, 1, 0, 0, 500, 0);
        tbl[10] = vv(3'b110, 500, 1, 3'd1, 1, 0, 1, 0, 1, 500, 0);
        tbl[11] = vv(3'b111,  10, 0, 3'd0, 0, 0, 0, 0, 0,   0, 0);
        tbl[12] = vv(3'b110, 200, 0, 3'd0, 0, 0, 0, 0, 0,   0, 0);
        tbl[13] = vv(3'b111,  40, 1, 3'd7, 0, 0, 0, 1, 0, 500, 1);
        tbl[14] = vv(3'b100, 500, 1, 3'd0, 1, 0, 0, 0, 0, 500, 1);
        tbl[15] = vv(3'b010, 500, 1, 3'd2, 1, 0, 0, 1, 0, 500, 2);
        tbl[16] = vv(3'b011, 500, 1, 3'd3, 1, 1, 1, 0, 0, 500, 2);
        tbl[17] = vv(3'b001, 300, 1, 3'd4, 1, 1, 1, 0, 1, 500, 2);
        tbl[18] = vv(3'b101, 500, 1, 3'd5, 1, 1, 1, 0, 1, 300, 2);

        repeat (4) @(posedge clk);
        @(negedge clk);
        check_reset("rst");
        @(posedge clk); #1;
        nRst   = 1'b1;
        mon_en = 1'b1;
        repeat (5) @(posedge clk);

        // First reference, then let the period counter run out.
        @(posedge clk); #1;
        drive(3'b100, 1'b1, mk(3'd0, 1, 0, 0, 0, 0, 0, 0, 0));
        repeat (LAT + TMO - 1) @(posedge clk);
        @(negedge clk);
        chk("stall_before_timeout", 32'(hStall), 0);
        @(negedge clk);
        chk("stall_at_timeout", 32'(hStall), 1);
        chk("pv_at_timeout", 32'(hPeriodValid), 0);
        repeat (80) @(posedge clk);

        for (int i = 0; i < 19; i++) begin
            apply(tbl[i]);
        end

        // Alternate between the two illegal codes to drive the error counter into saturation.
        for (int i = 0; i < 260; i++) begin
            apply(vv((i % 2 == 0) ? 3'b111 : 3'b000, 20, 1, 3'd7, 0, 1, 0, 1, 0, 300,
                     (3 + i > 255) ? 255 : 3 + i));
        end
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("errcnt_saturated", 32'(hErrCnt), 255);

        @(posedge clk); #1;
        clrErr = 1'b1;
        @(posedge clk); #1;
        clrErr = 1'b0;
        @(negedge clk);
        chk("errcnt_cleared", 32'(hErrCnt), 0);

        // clrErr lands on the same edge as an error pulse: the clear wins.
        @(posedge clk); #1;
        drive(3'b111, 1'b1, mk(3'd7, 0, 1, 0, 1, 0, 300, 0, 0));
        repeat (LAT - 1) @(posedge clk);
        #1 clrErr = 1'b1;
        @(posedge clk); #1;
        clrErr = 1'b0;
        repeat (3) @(posedge clk);

        apply(vv(3'b100, 100, 1, 3'd0, 1, 1, 0, 0, 0, 300, 0));

        // Reset mid-run, input held at a legal code throughout.
        mon_en = 1'b0;
        @(posedge clk); #1;
        nRst = 1'b0;
        @(posedge clk); #1;
        nRst = 1'b1;
        e = mk(3'd0, 1, 0, 0, 0, 0, 0, 0, 0);
        e.cyc = cyc + LAT;
        @(negedge clk);
        check_reset("midrst");
        sb.push_back(e);
        #1 mon_en = 1'b1;

        for (int k = 0; k < 200 && sb.size() != 0; k++) begin
            @(posedge clk);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 0);
        chk("final_step", 32'(hStep), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
        $finish;
    end

endmodule
